// File: rtl/sram_like_mem_responder.sv
// SRAM-like req/addr_ok/data_ok responder backed by a word-wide on-chip memory.
// Accepted requests wait in a small in-order queue and complete a fixed number of cycles later.
module sram_like_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int LATENCY     = 3,
  parameter int OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_stall,
  output logic        mem_addr_ok,
  output logic        mem_data_ok,
  output logic [31:0] mem_rdata
);
  // Handshake: a request is taken in any cycle where mem_req and mem_addr_ok are both high; the
  // requester holds mem_req and its attributes until then. mem_data_ok is a one-cycle completion
  // pulse, exactly one per accepted request, delivered in acceptance order.

  localparam int PTR_W  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W  = $clog2(OUTSTANDING + 1);
  localparam int AGE_W  = $clog2(LATENCY + 1);
  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam bit DIRECT = (LATENCY == 1);

  typedef enum logic {SLOT_EMPTY, SLOT_WAIT} slot_state_t;

  slot_state_t slot_state      [OUTSTANDING];
  slot_state_t slot_state_next [OUTSTANDING];

  logic                  q_wr    [OUTSTANDING];
  logic [ADDR_WIDTH-1:0] q_idx   [OUTSTANDING];
  logic [3:0]            q_mask  [OUTSTANDING];
  logic [31:0]           q_wdata [OUTSTANDING];
  logic [AGE_W-1:0]      q_age   [OUTSTANDING];

  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;

  logic [31:0]           mem [DEPTH];

  logic [ADDR_WIDTH-1:0] req_idx;
  logic [3:0]            req_mask;
  logic                  accept;
  logic                  push;
  logic                  head_due;
  logic                  pop;
  logic                  ret_valid;
  logic                  ret_wr;
  logic [ADDR_WIDTH-1:0] ret_idx;
  logic [3:0]            ret_mask;
  logic [31:0]           ret_wdata;
  logic                  unused_addr_bits;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(OUTSTANDING - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Upper address bits alias onto the same words.
  assign req_idx          = mem_addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^mem_addr[31:ADDR_WIDTH+2];

  always_comb begin
    req_mask = 4'b1111;
    case (mem_size)
      2'b00:   req_mask = 4'b0001 << mem_addr[1:0];
      2'b01:   req_mask = mem_addr[1] ? 4'b1100 : 4'b0011;
      default: req_mask = 4'b1111;
    endcase
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < OUTSTANDING; i++) begin
      if (slot_state[i] == SLOT_WAIT) count = count + 1'b1;
    end
  end

  // The occupancy seen here is the pre-edge count, so a same-cycle retirement never frees a slot.
  assign mem_addr_ok = mem_req & ~mem_stall & (count < CNT_W'(OUTSTANDING));
  assign accept      = mem_addr_ok;

  // age counts edges spent in the queue; the acceptance cycle is already the first latency cycle.
  assign head_due = (slot_state[head] == SLOT_WAIT) && ((int'(q_age[head]) + 2) >= LATENCY);
  assign push     = accept && !DIRECT;
  assign pop      = head_due && !DIRECT && !rst;

  // With a single-cycle latency the request completes at its own acceptance edge and never queues.
  always_comb begin
    if (DIRECT) begin
      ret_valid = accept && !rst;
      ret_wr    = mem_wr;
      ret_idx   = req_idx;
      ret_mask  = req_mask;
      ret_wdata = mem_wdata;
    end else begin
      ret_valid = pop;
      ret_wr    = q_wr[head];
      ret_idx   = q_idx[head];
      ret_mask  = q_mask[head];
      ret_wdata = q_wdata[head];
    end
  end

  always_comb begin
    for (int i = 0; i < OUTSTANDING; i++) slot_state_next[i] = slot_state[i];
    if (push) slot_state_next[tail] = SLOT_WAIT;
    if (pop)  slot_state_next[head] = SLOT_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OUTSTANDING; i++) slot_state[i] <= SLOT_EMPTY;
    end else begin
      for (int i = 0; i < OUTSTANDING; i++) slot_state[i] <= slot_state_next[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < OUTSTANDING; i++) begin
        q_wr[i]    <= 1'b0;
        q_idx[i]   <= '0;
        q_mask[i]  <= '0;
        q_wdata[i] <= '0;
        q_age[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        if (slot_state[i] == SLOT_WAIT && q_age[i] != AGE_W'(LATENCY)) q_age[i] <= q_age[i] + 1'b1;
      end
      if (push) begin
        q_wr[tail]    <= mem_wr;
        q_idx[tail]   <= req_idx;
        q_mask[tail]  <= req_mask;
        q_wdata[tail] <= mem_wdata;
        q_age[tail]   <= '0;
        tail          <= ptr_inc(tail);
      end
      if (pop) head <= ptr_inc(head);
    end
  end

  // Memory contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (ret_valid && ret_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (ret_mask[b]) mem[ret_idx][8*b +: 8] <= ret_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_data_ok <= 1'b0;
      mem_rdata   <= '0;
    end else begin
      mem_data_ok <= ret_valid;
      if (ret_valid && !ret_wr) mem_rdata <= mem[ret_idx];
    end
  end

endmodule

// File: tb/tb_sram_like_mem_responder.sv
// Directed bench for sram_like_mem_responder: scoreboarded transactions on a default instance,
// plus a small-queue instance whose addr_ok/data_ok cycle pattern is checked against constants.
module tb_sram_like_mem_responder;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_wr, mem_stall;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  logic        req_b, wr_b, stall_b;
  logic [1:0]  size_b;
  logic [31:0] addr_b, wdata_b;
  logic        addr_ok_b, data_ok_b;
  logic [31:0] rdata_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // {wr, due cycle, read data}
  logic [64:0] exp_q[$];
  logic [64:0] ent;
  logic [31:0] model_mem [1024];

  sram_like_mem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT), .OUTSTANDING(4)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_stall(mem_stall),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  sram_like_mem_responder #(.ADDR_WIDTH(10), .LATENCY(4), .OUTSTANDING(2)) dut_b (
    .clk(clk), .rst(rst), .mem_req(req_b), .mem_wr(wr_b), .mem_size(size_b),
    .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_stall(stall_b),
    .mem_addr_ok(addr_ok_b), .mem_data_ok(data_ok_b), .mem_rdata(rdata_b)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of stimulus, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   lane_mask = 4'b0001 << off;
      2'b01:   lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Present one request, hold it until accepted, record the expected completion.
  task automatic do_req(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic has_exp, input logic [31:0] exp_val,
                        output int waited);
    logic [9:0]  idx;
    logic [3:0]  m;
    logic [31:0] d;
    logic [31:0] due;
    @(negedge clk);
    mem_req = 1'b1; mem_wr = wr; mem_size = size; mem_addr = addr; mem_wdata = wdata;
    waited = 0;
    #1;
    while (mem_addr_ok !== 1'b1 && waited < 40) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("accept", {31'd0, mem_addr_ok}, 32'd1);
    if (mem_addr_ok === 1'b1) begin
      idx = addr[11:2];
      m   = lane_mask(size, addr[1:0]);
      d   = 32'd0;
      if (wr) begin
        for (int b = 0; b < 4; b++) if (m[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        d = has_exp ? exp_val : model_mem[idx];
      end
      due = cyc + LAT;
      exp_q.push_back({wr, due, d});
    end
    @(posedge clk);
    #1;
    mem_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  // scoreboard: every data_ok pulse pops the oldest expectation
  always @(posedge clk) begin
    #1;
    if (mem_data_ok === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_data_ok: observed pulse at cycle %0d, expected none", cyc);
      end
      if (exp_q.size() != 0) begin
        ent = exp_q.pop_front();
        check("data_ok_cycle", cyc, ent[63:32]);
        if (!ent[64]) check("rdata", mem_rdata, ent[31:0]);
      end
    end
  end

  initial begin
    int w;
    int accepted;
    logic [31:0] saved;
    logic [31:0] base;
    logic [31:0] alias_hi;
    logic [15:0] exp_ok_b;
    logic [15:0] exp_dok_b;

    rst = 1'b1;
    mem_req = 1'b0; mem_wr = 1'b0; mem_size = 2'b10; mem_addr = '0; mem_wdata = '0; mem_stall = 1'b0;
    req_b = 1'b0; wr_b = 1'b0; size_b = 2'b10; addr_b = '0; wdata_b = '0; stall_b = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_data_ok", {31'd0, mem_data_ok}, 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_addr_ok_idle", {31'd0, mem_addr_ok}, 32'd0);
    rst = 1'b0;

    // word write then read after completion
    do_req(1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0, w);
    drain();
    do_req(1'b0, 2'b10, 32'h10, 32'd0, 1'b1, 32'hDEADBEEF, w);
    drain();

    // byte and halfword merges into a known word (byte replicated on all lanes)
    do_req(1'b1, 2'b10, 32'h10, 32'h11223344, 1'b0, 32'd0, w);
    do_req(1'b1, 2'b00, 32'h13, 32'hAAAAAAAA, 1'b0, 32'd0, w);
    do_req(1'b0, 2'b00, 32'h10, 32'd0, 1'b1, 32'hAA223344, w);
    do_req(1'b1, 2'b01, 32'h12, 32'h55669999, 1'b0, 32'd0, w);
    do_req(1'b0, 2'b01, 32'h11, 32'd0, 1'b1, 32'h55663344, w);
    drain();

    // random partial writes, sizes, offsets and aliased upper address bits
    for (int k = 0; k < 8; k++) begin
      base     = 32'h100 + 32'(4 * k);
      alias_hi = 32'($urandom_range(0, 255)) << 12;
      do_req(1'b1, 2'b10, base | alias_hi, $urandom, 1'b0, 32'd0, w);
      do_req(1'b1, 2'($urandom_range(0, 3)), base + 32'($urandom_range(0, 3)), $urandom, 1'b0, 32'd0, w);
      do_req(1'b0, 2'($urandom_range(0, 3)), base + 32'($urandom_range(0, 3)), 32'd0, 1'b0, 32'd0, w);
    end
    drain();

    // six held reads back to back: all taken without waiting, completions consecutive
    for (int k = 0; k < 6; k++) begin
      do_req(1'b0, 2'b10, 32'h100 + 32'(4 * k), 32'd0, 1'b0, 32'd0, w);
      check("b2b_no_wait", w, 32'd0);
    end
    drain();

    // stall blocks acceptance while queued entries still complete on time
    do_req(1'b0, 2'b10, 32'h104, 32'd0, 1'b0, 32'd0, w);
    do_req(1'b0, 2'b10, 32'h108, 32'd0, 1'b0, 32'd0, w);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mem_stall = 1'b1; mem_req = 1'b1; mem_wr = 1'b0; mem_size = 2'b10; mem_addr = 32'h10;
      #1;
      check("stall_addr_ok", {31'd0, mem_addr_ok}, 32'd0);
    end
    mem_req = 1'b0;
    mem_stall = 1'b0;
    do_req(1'b0, 2'b10, 32'h10, 32'd0, 1'b1, 32'h55663344, w);
    check("post_stall_no_wait", w, 32'd0);
    drain();

    // write immediately followed by read of the same word
    do_req(1'b1, 2'b10, 32'h20, 32'hCAFEF00D, 1'b0, 32'd0, w);
    do_req(1'b0, 2'b10, 32'h20, 32'd0, 1'b1, 32'hCAFEF00D, w);
    drain();

    // small-queue instance: LATENCY 4, two slots, request held for six accepts
    exp_ok_b  = 16'h0333;
    exp_dok_b = 16'h3330;
    accepted  = 0;
    @(negedge clk);
    req_b = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      check($sformatf("b_addr_ok_c%0d", i), {31'd0, addr_ok_b}, {31'd0, exp_ok_b[i]});
      check($sformatf("b_data_ok_c%0d", i), {31'd0, data_ok_b}, {31'd0, exp_dok_b[i]});
      if (addr_ok_b === 1'b1) accepted++;
      @(posedge clk);
      #1;
      if (accepted == 6) req_b = 1'b0;
      @(negedge clk);
    end

    // reset with transactions in flight: dropped silently, earlier writes survive
    do_req(1'b1, 2'b10, 32'h30, 32'h13579BDF, 1'b0, 32'd0, w);
    drain();
    saved = model_mem[12];
    do_req(1'b0, 2'b10, 32'h10, 32'd0, 1'b0, 32'd0, w);
    do_req(1'b1, 2'b10, 32'h30, 32'hFFFFFFFF, 1'b0, 32'd0, w);
    @(negedge clk);
    mem_req = 1'b1; mem_wr = 1'b0; mem_size = 2'b10; mem_addr = 32'h30;
    #1;
    rst = 1'b1;
    mem_req = 1'b0;
    exp_q.delete();
    model_mem[12] = saved;
    #1;
    check("midrst_data_ok", {31'd0, mem_data_ok}, 32'd0);
    check("midrst_rdata", mem_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_rst_quiet", {31'd0, mem_data_ok}, 32'd0);
    end
    do_req(1'b0, 2'b10, 32'h30, 32'd0, 1'b1, 32'h13579BDF, w);
    do_req(1'b0, 2'b10, 32'h10, 32'd0, 1'b1, 32'h55663344, w);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
